keypad_scan_ctl: RTL and testbench

//   Input-side counterpart of the 7-segment scan timing: scans a 4x4 active-low key matrix.

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/keypad_frame_sampler.sv | 71 +++++++
 rtl/keypad_scan_ctl.sv | 179 +++++++++++++++++
 tb/tb_keypad_scan_ctl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and sizes for the 4x4 active-low keypad scanner.
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEB   = 2'd1,
    PRESS = 2'd2,
    REL   = 2'd3
  } kp_state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } frame_class_e;

  // Frame map bit index is col*4+row; key code is row*4+col.
  function automatic logic [KEY_W-1:0] map_idx_to_key(input logic [3:0] idx);
    return {idx[1:0], idx[3:2]};
  endfunction
endpackage

// File: rtl/keypad_frame_sampler.sv
// Column scan counter, row synchronizer and per-frame key map with classification.
module keypad_frame_sampler
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic                frame_end,
  output frame_class_e        frame_class,
  output logic [KEY_W-1:0]    frame_key
);
  localparam int SCAN_W = SCAN_DIV_W + 2;

  logic [SCAN_W-1:0]     scan_q;
  logic [1:0]            col_idx;
  logic                  sample;
  logic [NUM_ROWS-1:0]   sync1_q;
  logic [NUM_ROWS-1:0]   sync2_q;
  logic [15:0]           map_q;
  logic [15:0]           map_full;
  logic [4:0]            hits;

  assign col_idx   = scan_q[SCAN_W-1:SCAN_DIV_W];
  assign sample    = &scan_q[SCAN_DIV_W-1:0];
  assign col_out   = ~(4'b0001 << col_idx);
  assign frame_end = sample & (col_idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q  <= '0;
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      map_q   <= 16'h0000;
    end else begin
      scan_q  <= scan_q + SCAN_W'(1);
      sync1_q <= row_in;
      sync2_q <= sync1_q;
      if (sample) begin
        map_q[{col_idx, 2'b00} +: 4] <= ~sync2_q;
      end else begin
        map_q <= map_q;
      end
    end
  end

  // Column 3 is classified from the live sample so the verdict is ready on frame_end.
  always_comb begin
    map_full          = map_q;
    map_full[12 +: 4] = ~sync2_q;
    hits              = 5'd0;
    frame_key         = '0;
    for (int i = 0; i < 16; i++) begin
      hits = hits + {4'd0, map_full[i]};
      if (map_full[i]) begin
        frame_key = map_idx_to_key(4'(i));
      end else begin
        frame_key = frame_key;
      end
    end
    if (hits == 5'd0) begin
      frame_class = NONE;
    end else if (hits == 5'd1) begin
      frame_class = SINGLE;
    end else begin
      frame_class = MULTI;
    end
  end
endmodule

// File: rtl/keypad_scan_ctl.sv
// 4x4 keypad scanner with frame-level press/release debounce and a one-cycle key_valid pulse.
// Optional auto-repeat while a key stays held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scan_ctl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W    = 15,
  parameter int DEBOUNCE_FRMS = 4
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_FRMS   = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col_out,
  input  logic [3:0] row_in,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int               CNT_W    = $clog2(DEBOUNCE_FRMS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_FRMS);

  logic             frame_end;
  frame_class_e     fclass;
  logic [KEY_W-1:0] fkey;

  kp_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int               RPT_W    = $clog2(REPEAT_FRMS + 1);
  localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_FRMS);
  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  keypad_frame_sampler #(.SCAN_DIV_W(SCAN_DIV_W)) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .row_in     (row_in),
    .col_out    (col_out),
    .frame_end  (frame_end),
    .frame_class(fclass),
    .frame_key  (fkey)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_d   = rpt_q;
`endif
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (fclass == SINGLE) begin
            cand_d = fkey;
            // A single-frame debounce accepts on the very frame that would enter DEB.
            if (DEB_LAST == CNT_ONE) begin
              state_d = PRESS;
              cnt_d   = '0;
              code_d  = fkey;
              valid_d = 1'b1;
              held_d  = 1'b1;
            end else begin
              state_d = DEB;
              cnt_d   = CNT_ONE;
            end
          end else begin
            state_d = IDLE;
          end
        end
        DEB: begin
          if ((fclass == SINGLE) && (fkey == cand_q)) begin
            if ((cnt_q + CNT_ONE) == DEB_LAST) begin
              state_d = PRESS;
              cnt_d   = '0;
              code_d  = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESS: begin
          if (fclass == NONE) begin
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_d = '0;
`endif
            if (DEB_LAST == CNT_ONE) begin
              state_d = IDLE;
              cnt_d   = '0;
              held_d  = 1'b0;
            end else begin
              state_d = REL;
              cnt_d   = CNT_ONE;
            end
          end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if ((fclass == SINGLE) && (fkey == code_q)) begin
              if ((rpt_q + RPT_ONE) == RPT_LAST) begin
                valid_d = 1'b1;
                rpt_d   = '0;
              end else begin
                rpt_d = rpt_q + RPT_ONE;
              end
            end else begin
              rpt_d = '0;
            end
`else
            state_d = PRESS;
`endif
          end
        end
        REL: begin
          if (fclass == NONE) begin
            if ((cnt_q + CNT_ONE) == DEB_LAST) begin
              state_d = IDLE;
              cnt_d   = '0;
              held_d  = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            state_d = PRESS;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
endmodule

// File: tb/tb_keypad_scan_ctl.sv
// Directed bench for keypad_scan_ctl with SCAN_DIV_W=2 (16 clk/frame) and DEBOUNCE_FRMS=2.
module tb_keypad_scan_ctl;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_out;
  logic [3:0]  row_in;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed;
  int          chk_cnt  = 0;
  int          pass_cnt = 0;

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key (index row*4+col) pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!col_out[c] && pressed[r*4+c]) row_in[r] = 1'b0;
      end
    end
  end

  keypad_scan_ctl #(
    .SCAN_DIV_W   (2),
    .DEBOUNCE_FRMS(2)
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    .REPEAT_FRMS  (3)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col_out  (col_out),
    .row_in   (row_in),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // Leaves the caller on the negedge of cycle 0 of frame 0.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One frame from cycle 0 to cycle 0 of the next frame; a pulse from this frame's end lands at pos 16.
  task automatic run_frame(output int pulses, output int pos);
    pulses = 0;
    pos    = -1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        pulses++;
        pos = i;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    chk_cnt++; if (col_out !== 4'b1110) $display("FAIL rst_col: got %b want 1110", col_out); else pass_cnt++;
    chk_cnt++; if (key_code !== 4'd0) $display("FAIL rst_code: got %0d want 0", key_code); else pass_cnt++;
    chk_cnt++; if (key_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", key_valid); else pass_cnt++;
    chk_cnt++; if (key_held !== 1'b0) $display("FAIL rst_held: got %b want 0", key_held); else pass_cnt++;
    repeat (5) @(negedge clk);
    chk_cnt++; if (col_out !== 4'b1110) $display("FAIL rst_col_frozen: got %b want 1110", col_out); else pass_cnt++;
  endtask

  task automatic test_scan();
    logic [3:0] exp_col;
    @(negedge clk);
    rst = 1'b0;
    chk_cnt++; if (col_out !== 4'b1110) $display("FAIL scan_col0: got %b want 1110", col_out); else pass_cnt++;
    for (int s = 1; s < 8; s++) begin
      repeat (4) @(negedge clk);
      exp_col = ~(4'b0001 << (s % 4));
      chk_cnt++; if (col_out !== exp_col) $display("FAIL scan_step%0d: got %b want %b", s, col_out, exp_col); else pass_cnt++;
    end
  endtask

  task automatic test_press_hold();
    int p, pos;
    do_reset();
    pressed = 16'h0040;
    run_frame(p, pos);
    chk_cnt++; if (p !== 0) $display("FAIL hold_f0_pulse: got %0d want 0", p); else pass_cnt++;
    run_frame(p, pos);
    chk_cnt++; if (p !== 1) $display("FAIL hold_f1_pulses: got %0d want 1", p); else pass_cnt++;
    chk_cnt++; if (pos !== 16) $display("FAIL hold_latency: got %0d want 16", pos); else pass_cnt++;
    chk_cnt++; if (key_code !== 4'd6) $display("FAIL hold_code: got %0d want 6", key_code); else pass_cnt++;
    chk_cnt++; if (key_held !== 1'b1) $display("FAIL hold_held: got %b want 1", key_held); else pass_cnt++;
    run_frame(p, pos);
    chk_cnt++; if (p !== 0) $display("FAIL hold_f2_pulse: got %0d want 0", p); else pass_cnt++;
    chk_cnt++; if (key_held !== 1'b1) $display("FAIL hold_f2_held: got %b want 1", key_held); else pass_cnt++;
  endtask

  task automatic test_short_press();
    int p, pos, tot;
    do_reset();
    pressed = 16'h0040;
    run_frame(p, pos);
    tot = p;
    pressed = 16'h0000;
    run_frame(p, pos);
    tot += p;
    run_frame(p, pos);
    tot += p;
    chk_cnt++; if (tot !== 0) $display("FAIL short_pulses: got %0d want 0", tot); else pass_cnt++;
    chk_cnt++; if (key_held !== 1'b0) $display("FAIL short_held: got %b want 0", key_held); else pass_cnt++;
    pressed = 16'h0040;
    run_frame(p, pos);
    chk_cnt++; if (p !== 0) $display("FAIL short_idle_f0: got %0d want 0", p); else pass_cnt++;
    run_frame(p, pos);
    chk_cnt++; if (p !== 1) $display("FAIL short_idle_f1: got %0d want 1", p); else pass_cnt++;
    pressed = 16'h0000;
    run_frame(p, pos);
    chk_cnt++; if (key_held !== 1'b1) $display("FAIL rel_f0_held: got %b want 1", key_held); else pass_cnt++;
    run_frame(p, pos);
    chk_cnt++; if (key_held !== 1'b0) $display("FAIL rel_f1_held: got %b want 0", key_held); else pass_cnt++;
    chk_cnt++; if (key_code !== 4'd6) $display("FAIL rel_code_kept: got %0d want 6", key_code); else pass_cnt++;
  endtask

  task automatic test_multi();
    int p, pos, tot;
    tot = 0;
    pressed = 16'h0021;
    for (int f = 0; f < 4; f++) begin
      run_frame(p, pos);
      tot += p;
    end
    chk_cnt++; if (tot !== 0) $display("FAIL multi_pulses: got %0d want 0", tot); else pass_cnt++;
    chk_cnt++; if (key_code !== 4'd6) $display("FAIL multi_code: got %0d want 6", key_code); else pass_cnt++;
    pressed = 16'h0001;
    run_frame(p, pos);
    chk_cnt++; if (p !== 0) $display("FAIL multi_rel_f0: got %0d want 0", p); else pass_cnt++;
    run_frame(p, pos);
    chk_cnt++; if (p !== 1) $display("FAIL multi_rel_f1: got %0d want 1", p); else pass_cnt++;
    chk_cnt++; if (key_code !== 4'd0) $display("FAIL multi_rel_code: got %0d want 0", key_code); else pass_cnt++;
  endtask

  task automatic test_bounce();
    int p, pos, tot;
    pressed = 16'h0000;
    run_frame(p, pos);
    run_frame(p, pos);
    pressed = 16'h0040;
    run_frame(p, pos);
    run_frame(p, pos);
    chk_cnt++; if (key_code !== 4'd6 || p !== 1) $display("FAIL bounce_setup: got code %0d pulses %0d want 6/1", key_code, p); else pass_cnt++;
    pressed = 16'h0000;
    run_frame(p, pos);
    tot = p;
    pressed = 16'h0040;
    run_frame(p, pos);
    tot += p;
    chk_cnt++; if (key_held !== 1'b1) $display("FAIL bounce_held: got %b want 1", key_held); else pass_cnt++;
    pressed = 16'h0000;
    run_frame(p, pos);
    tot += p;
    chk_cnt++; if (key_held !== 1'b1) $display("FAIL bounce_rel_f0: got %b want 1", key_held); else pass_cnt++;
    run_frame(p, pos);
    tot += p;
    chk_cnt++; if (key_held !== 1'b0) $display("FAIL bounce_rel_f1: got %b want 0", key_held); else pass_cnt++;
    chk_cnt++; if (tot !== 0) $display("FAIL bounce_pulses: got %0d want 0", tot); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int p, pos;
    pressed = 16'h0040;
    run_frame(p, pos);
    run_frame(p, pos);
    chk_cnt++; if (key_held !== 1'b1) $display("FAIL midrst_pre_held: got %b want 1", key_held); else pass_cnt++;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_cnt++; if (col_out !== 4'b1110) $display("FAIL midrst_col: got %b want 1110", col_out); else pass_cnt++;
    chk_cnt++; if (key_code !== 4'd0 || key_valid !== 1'b0 || key_held !== 1'b0)
      $display("FAIL midrst_outs: got code %0d valid %b held %b want 0/0/0", key_code, key_valid, key_held); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_frame(p, pos);
    chk_cnt++; if (p !== 0) $display("FAIL midrst_f0: got %0d want 0", p); else pass_cnt++;
    run_frame(p, pos);
    chk_cnt++; if (p !== 1 || pos !== 16) $display("FAIL midrst_f1: got %0d at %0d want 1 at 16", p, pos); else pass_cnt++;
    pressed = 16'h0000;
  endtask

`ifdef KEYPAD_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int p, pos, exp_p;
    do_reset();
    pressed = 16'h0200;
    for (int f = 0; f < 10; f++) begin
      run_frame(p, pos);
      exp_p = (f == 1 || f == 4 || f == 7) ? 1 : 0;
      chk_cnt++; if (p !== exp_p) $display("FAIL rpt_frame%0d: got %0d want %0d", f, p, exp_p); else pass_cnt++;
    end
    chk_cnt++; if (key_code !== 4'd9) $display("FAIL rpt_code: got %0d want 9", key_code); else pass_cnt++;
    pressed = 16'h0000;
  endtask
`endif

  initial begin
    rst     = 1'b1;
    pressed = 16'h0000;
    test_reset();
    test_scan();
    test_press_hold();
    test_short_press();
    test_multi();
    test_bounce();
    test_mid_reset();
`ifdef KEYPAD_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
